seq_mult_ctrl: RTL and testbench

SEQ_MULT_CTRL -- requirements
Module: seq_mult_ctrl

---
 rtl/seq_mult_ctrl.sv | 153 +++++++++++++++
 tb/tb_seq_mult_ctrl.sv | 269 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/seq_mult_ctrl.sv
// Sequential shift-and-add unsigned multiplier with IDLE/CALC/DONE control FSM.
// One accumulator step per CALC cycle, so an operation takes exactly WIDTH cycles.

module half_adder (
  input  logic x_i,
  input  logic y_i,
  output logic s_o,
  output logic c_o
);
  assign s_o = x_i ^ y_i;
  assign c_o = x_i & y_i;
endmodule

module full_adder (
  input  logic x_i,
  input  logic y_i,
  input  logic c_i,
  output logic s_o,
  output logic c_o
);
  assign s_o = x_i ^ y_i ^ c_i;
  assign c_o = (x_i & y_i) | (c_i & (x_i ^ y_i));
endmodule

module seq_mult_ctrl #(
  parameter int WIDTH = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic               ready,
  output logic               busy,
  output logic               done,
  output logic [2*WIDTH-1:0] product
);

  localparam int PW = 2 * WIDTH;
  localparam int CW = $clog2(WIDTH) + 1;
  localparam logic [CW-1:0] LAST_COUNT = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t          state_q;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic [PW-1:0]   acc_q;
  logic [CW-1:0]   count_q;
  logic [PW-1:0]   product_q;
  logic            ready_q;
  logic            busy_q;
  logic            done_q;

  logic [PW-1:0]   addend;
  logic [PW-1:0]   acc_sum;
  logic [PW-2:0]   carry;
  logic            carry_msb_unused;

  // Partial product for this step: the multiplicand aligned to the current multiplier bit.
  assign addend = b_q[0] ? ({{WIDTH{1'b0}}, a_q} << count_q) : '0;

  // Ripple-carry accumulator adder; the MSB carry-out cannot be set for legal operands.
  half_adder u_ha0 (
    .x_i (acc_q[0]),
    .y_i (addend[0]),
    .s_o (acc_sum[0]),
    .c_o (carry[0])
  );

  for (genvar i = 1; i < PW - 1; i++) begin : g_fa
    full_adder u_fa (
      .x_i (acc_q[i]),
      .y_i (addend[i]),
      .c_i (carry[i-1]),
      .s_o (acc_sum[i]),
      .c_o (carry[i])
    );
  end

  full_adder u_fa_msb (
    .x_i (acc_q[PW-1]),
    .y_i (addend[PW-1]),
    .c_i (carry[PW-2]),
    .s_o (acc_sum[PW-1]),
    .c_o (carry_msb_unused)
  );

  // Status flags are registered alongside the state, so each is a pure function of it.
  always_ff @(posedge clk) begin
    // NOTE: every register here is written with <= so all updates see pre-edge values.
    if (rst) begin
      state_q   <= IDLE;
      a_q       <= '0;
      b_q       <= '0;
      acc_q     <= '0;
      count_q   <= '0;
      product_q <= '0;
      ready_q   <= 1'b1;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (start) begin
            state_q <= CALC;
            a_q     <= a;
            b_q     <= b;
            acc_q   <= '0;
            count_q <= '0;
            ready_q <= 1'b0;
            busy_q  <= 1'b1;
            done_q  <= 1'b0;
          end
        end
        CALC: begin
          acc_q   <= acc_sum;
          b_q     <= b_q >> 1;
          count_q <= count_q + 1'b1;
          if (count_q == LAST_COUNT) begin
            state_q   <= DONE;
            product_q <= acc_sum;
            ready_q   <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b1;
          end
        end
        DONE: begin
          state_q <= IDLE;
          ready_q <= 1'b1;
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
        end
        default: begin
          state_q <= IDLE;
          ready_q <= 1'b1;
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
        end
      endcase
    end
  end

  assign ready   = ready_q;
  assign busy    = busy_q;
  assign done    = done_q;
  assign product = product_q;

endmodule

// File: tb/tb_seq_mult_ctrl.sv
// Directed bench for seq_mult_ctrl at WIDTH=8: reset, products, latency, ignored start,
// abort by reset and a long back-to-back run.

module tb_seq_mult_ctrl;

  localparam int W = 8;

  logic           clk;
  logic           rst;
  logic           start;
  logic [W-1:0]   a;
  logic [W-1:0]   b;
  logic           ready;
  logic           busy;
  logic           done;
  logic [2*W-1:0] product;

  int errors = 0;
  int checks = 0;

  seq_mult_ctrl #(.WIDTH(W)) dut (
    .clk     (clk),
    .rst     (rst),
    .start   (start),
    .a       (a),
    .b       (b),
    .ready   (ready),
    .busy    (busy),
    .done    (done),
    .product (product)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Launches one operation from IDLE (called at a negedge) and returns at the negedge
  // where done is seen; lat counts edges after the accepting edge.
  task automatic run_op(input logic [W-1:0] op_a, input logic [W-1:0] op_b,
                        output int busy_cnt, output int lat, output logic timed_out);
    start = 1'b1;
    a     = op_a;
    b     = op_b;
    @(negedge clk);
    start    = 1'b0;
    busy_cnt = 0;
    lat      = 0;
    while (done !== 1'b1 && lat < 40) begin
      if (busy === 1'b1) busy_cnt++;
      lat++;
      @(negedge clk);
    end
    timed_out = (lat >= 40);
  endtask

  task automatic test_reset();
    rst   = 1'b1;
    start = 1'b0;
    a     = '0;
    b     = '0;
    repeat (2) @(negedge clk);
    checks++;
    if ({ready, busy, done} !== 3'b100) begin
      errors++;
      $display("FAIL reset_flags: got rdy/bsy/dn=%b expected 100", {ready, busy, done});
    end
    checks++;
    if (product !== 16'h0000) begin
      errors++;
      $display("FAIL reset_product: got %h expected 0000", product);
    end
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if (ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_release_ready: got %b expected 1", ready);
    end
  endtask

  task automatic test_basic();
    int busy_cnt, lat;
    logic to;
    run_op(8'd13, 8'd11, busy_cnt, lat, to);
    checks++;
    if (to || lat != 8) begin
      errors++;
      $display("FAIL basic_latency: got %0d edges (timeout=%b) expected 8", lat, to);
    end
    checks++;
    if (busy_cnt != 8) begin
      errors++;
      $display("FAIL basic_busy_cycles: got %0d expected 8", busy_cnt);
    end
    checks++;
    if (product !== 16'h008F) begin
      errors++;
      $display("FAIL basic_product: got %h expected 008f", product);
    end
    @(negedge clk);
    checks++;
    if ({ready, busy, done} !== 3'b100) begin
      errors++;
      $display("FAIL basic_done_one_cycle: got rdy/bsy/dn=%b expected 100", {ready, busy, done});
    end
  endtask

  task automatic test_max_zero();
    int busy_cnt, lat;
    logic to;
    run_op(8'd255, 8'd255, busy_cnt, lat, to);
    checks++;
    if (to || lat != 8 || product !== 16'hFE01) begin
      errors++;
      $display("FAIL max_product: got %h lat=%0d expected fe01 lat=8", product, lat);
    end
    @(negedge clk);
    run_op(8'd0, 8'd200, busy_cnt, lat, to);
    checks++;
    if (to || lat != 8 || product !== 16'h0000) begin
      errors++;
      $display("FAIL zero_product: got %h lat=%0d expected 0000 lat=8", product, lat);
    end
    @(negedge clk);
  endtask

  task automatic test_start_ignored();
    int lat;
    start = 1'b1;
    a     = 8'd3;
    b     = 8'd5;
    @(negedge clk);
    a   = 8'd7;
    b   = 8'd7;
    lat = 0;
    while (done !== 1'b1 && lat < 40) begin
      lat++;
      @(negedge clk);
    end
    checks++;
    if (lat != 8 || product !== 16'd15) begin
      errors++;
      $display("FAIL ignore_first_op: got %0d lat=%0d expected 15 lat=8", product, lat);
    end
    @(negedge clk);
    checks++;
    if ({ready, busy, done} !== 3'b100) begin
      errors++;
      $display("FAIL ignore_back_idle: got rdy/bsy/dn=%b expected 100", {ready, busy, done});
    end
    @(negedge clk);
    start = 1'b0;
    checks++;
    if (busy !== 1'b1 || product !== 16'd15) begin
      errors++;
      $display("FAIL ignore_hold_product: got busy=%b product=%0d expected 1 15", busy, product);
    end
    lat = 0;
    while (done !== 1'b1 && lat < 40) begin
      lat++;
      @(negedge clk);
    end
    checks++;
    if (lat != 8 || product !== 16'd49) begin
      errors++;
      $display("FAIL ignore_second_op: got %0d lat=%0d expected 49 lat=8", product, lat);
    end
    @(negedge clk);
  endtask

  task automatic test_abort();
    int busy_cnt, lat;
    logic to;
    logic seen_done;
    start = 1'b1;
    a     = 8'd100;
    b     = 8'd100;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if (busy !== 1'b1) begin
      errors++;
      $display("FAIL abort_in_calc: got busy=%b expected 1", busy);
    end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    checks++;
    if ({ready, busy, done} !== 3'b100 || product !== 16'h0000) begin
      errors++;
      $display("FAIL abort_state: got rdy/bsy/dn=%b product=%h expected 100 0000",
               {ready, busy, done}, product);
    end
    seen_done = 1'b0;
    repeat (12) begin
      @(negedge clk);
      if (done === 1'b1) seen_done = 1'b1;
    end
    checks++;
    if (seen_done !== 1'b0) begin
      errors++;
      $display("FAIL abort_no_done: got done pulse expected none");
    end
    run_op(8'd2, 8'd3, busy_cnt, lat, to);
    checks++;
    if (to || lat != 8 || product !== 16'd6) begin
      errors++;
      $display("FAIL abort_next_op: got %0d lat=%0d expected 6 lat=8", product, lat);
    end
    @(negedge clk);
  endtask

  task automatic test_back_to_back();
    int ops = 0;
    int cyc = 0;
    int last_done = -1;
    logic [2*W-1:0] exp_prod = '0;
    start = 1'b1;
    while (ops < 1000 && cyc < 10200) begin
      checks++;
      if (!$onehot({ready, busy, done})) begin
        errors++;
        $display("FAIL b2b_exclusive: cycle %0d got rdy/bsy/dn=%b expected one-hot",
                 cyc, {ready, busy, done});
      end
      if (done === 1'b1) begin
        checks++;
        if (product !== exp_prod) begin
          errors++;
          $display("FAIL b2b_product: op %0d got %h expected %h", ops, product, exp_prod);
        end
        if (last_done >= 0) begin
          checks++;
          if (cyc - last_done != 10) begin
            errors++;
            $display("FAIL b2b_spacing: op %0d got %0d cycles expected 10", ops, cyc - last_done);
          end
        end
        last_done = cyc;
        ops++;
      end
      if (ready === 1'b1) begin
        a        = W'($urandom);
        b        = W'($urandom);
        exp_prod = (2*W)'(a) * (2*W)'(b);
      end
      cyc++;
      @(negedge clk);
    end
    start = 1'b0;
    checks++;
    if (ops != 1000) begin
      errors++;
      $display("FAIL b2b_count: got %0d operations expected 1000", ops);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_max_zero();
    test_start_ignored();
    test_abort();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
